// File: rtl/vector_pkg.sv
// Shared constants and state encoding for the vector load/store datapath.
package vector_pkg;

  localparam int VEC_WIDTH  = 128;
  localparam int WORD_WIDTH = 32;
  localparam int LANES      = VEC_WIDTH / WORD_WIDTH;
  localparam int ADDR_STEP  = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } gather_state_t;

endpackage

// File: rtl/vector_ld_gather.sv
// Vector-load gather: issues LANES sequential word reads and assembles them
// into one vector, presented with a single-cycle valid pulse.
module vector_ld_gather
  import vector_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_ren_v,
  input  logic [WORD_WIDTH-1:0] m_address,
  input  logic [WORD_WIDTH-1:0] mem_rdata,
  output logic [WORD_WIDTH-1:0] mem_raddr,
  output logic                  mem_ren,
  output logic                  stall_cpu,
  output logic [VEC_WIDTH-1:0]  output_vector,
  output logic                  vector_valid
);

  localparam int                    LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0]     LAST_LANE = LANE_W'(LANES - 1);
  localparam logic [WORD_WIDTH-1:0] STEP      = WORD_WIDTH'(ADDR_STEP);

  gather_state_t         state_q;
  logic [LANE_W-1:0]     lane_q;
  logic [WORD_WIDTH-1:0] raddr_q;
  logic                  ren_q;
  logic                  valid_q;
  logic [VEC_WIDTH-1:0]  asm_q;
  logic [VEC_WIDTH-1:0]  asm_d;
  logic [VEC_WIDTH-1:0]  vec_q;

  logic                  accept;
  logic                  capture;
  logic [LANE_W-1:0]     cap_lane;

  // Read data lags its address by one cycle, so the lane landing now is the
  // one issued last cycle; DRAIN catches the final lane.
  always_comb begin
    accept   = ((state_q == IDLE) || (state_q == DONE)) && mem_ren_v;
    capture  = ((state_q == READ) && (lane_q != '0)) || (state_q == DRAIN);
    cap_lane = (state_q == DRAIN) ? LAST_LANE : (lane_q - LANE_W'(1));
    asm_d    = asm_q;
    if (capture) begin
      asm_d[cap_lane*WORD_WIDTH +: WORD_WIDTH] = mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      raddr_q <= '0;
      ren_q   <= 1'b0;
      valid_q <= 1'b0;
      asm_q   <= '0;
      vec_q   <= '0;
    end else begin
      valid_q <= 1'b0;
      asm_q   <= asm_d;
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            state_q <= READ;
            lane_q  <= '0;
            raddr_q <= m_address;
            ren_q   <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        READ: begin
          if (lane_q == LAST_LANE) begin
            state_q <= DRAIN;
            ren_q   <= 1'b0;
          end else begin
            lane_q  <= lane_q + LANE_W'(1);
            raddr_q <= raddr_q + STEP;
          end
        end
        DRAIN: begin
          // Load the merged value so the final lane is included.
          state_q <= DONE;
          vec_q   <= asm_d;
          valid_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ren_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall_cpu     = !rst && (accept || (state_q == READ) || (state_q == DRAIN));
  assign mem_raddr     = raddr_q;
  assign mem_ren       = ren_q;
  assign output_vector = vec_q;
  assign vector_valid  = valid_q;

endmodule

// File: tb/tb_vector_ld_gather.sv
// Directed bench for vector_ld_gather with a 1-cycle-latency RAM model.
module tb_vector_ld_gather;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_ren_v;
  logic [31:0]  m_address;
  logic [31:0]  mem_rdata;
  logic [31:0]  mem_raddr;
  logic         mem_ren;
  logic         stall_cpu;
  logic [127:0] output_vector;
  logic         vector_valid;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [127:0] VEC_BASIC  = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] VEC_WRAP   = 128'h04040404_00C0FFEE_FCFCFCFC_F8F8F8F8;
  localparam logic [127:0] VEC_SECOND = 128'hD3D3D3D3_C2C2C2C2_B1B1B1B1_A0A0A0A0;

  vector_ld_gather dut (
    .clk          (clk),
    .rst          (rst),
    .mem_ren_v    (mem_ren_v),
    .m_address    (m_address),
    .mem_rdata    (mem_rdata),
    .mem_raddr    (mem_raddr),
    .mem_ren      (mem_ren),
    .stall_cpu    (stall_cpu),
    .output_vector(output_vector),
    .vector_valid (vector_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ramRead(input logic [31:0] a);
    case (a)
      32'h00000010: ramRead = 32'h11111111;
      32'h00000014: ramRead = 32'h22222222;
      32'h00000018: ramRead = 32'h33333333;
      32'h0000001C: ramRead = 32'h44444444;
      32'h00000020: ramRead = 32'hA0A0A0A0;
      32'h00000024: ramRead = 32'hB1B1B1B1;
      32'h00000028: ramRead = 32'hC2C2C2C2;
      32'h0000002C: ramRead = 32'hD3D3D3D3;
      32'hFFFFFFF8: ramRead = 32'hF8F8F8F8;
      32'hFFFFFFFC: ramRead = 32'hFCFCFCFC;
      32'h00000000: ramRead = 32'h00C0FFEE;
      32'h00000004: ramRead = 32'h04040404;
      default:      ramRead = a ^ 32'h5A5A5A5A;
    endcase
  endfunction

  // Garbage when not reading exposes any capture on the wrong cycle.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= ramRead(mem_raddr);
    else         mem_rdata <= 32'hBAD0BAD0;
  end

  task automatic test_reset();
    rst = 1'b1; mem_ren_v = 1'b1; m_address = 32'h10;
    repeat (3) @(negedge clk);
    #1;
    compared++; if (stall_cpu !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall got %b expected 0", stall_cpu); end
    compared++; if (mem_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ren got %b expected 0", mem_ren); end
    compared++; if (mem_raddr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_raddr got %h expected 0", mem_raddr); end
    compared++; if (output_vector !== 128'h0) begin mismatched++; $display("[TB] FAIL reset_vec got %h expected 0", output_vector); end
    compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b expected 0", vector_valid); end
    @(negedge clk);
    rst = 1'b0; mem_ren_v = 1'b0; m_address = 32'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    logic [31:0] expAddr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0); m_address = (c == 0) ? 32'h10 : 32'h0;
      #1;
      compared++; if (stall_cpu !== (c <= 5)) begin mismatched++; $display("[TB] FAIL basic_stall c%0d got %b expected %b", c, stall_cpu, c <= 5); end
      compared++; if (mem_ren !== (c >= 1 && c <= 4)) begin mismatched++; $display("[TB] FAIL basic_ren c%0d got %b", c, mem_ren); end
      compared++; if (vector_valid !== (c == 6)) begin mismatched++; $display("[TB] FAIL basic_valid c%0d got %b", c, vector_valid); end
      if (c >= 1 && c <= 4) begin
        compared++; if (mem_raddr !== expAddr[c-1]) begin mismatched++; $display("[TB] FAIL basic_raddr c%0d got %h expected %h", c, mem_raddr, expAddr[c-1]); end
      end
      if (c == 6) begin
        compared++; if (output_vector !== VEC_BASIC) begin mismatched++; $display("[TB] FAIL basic_vec got %h expected %h", output_vector, VEC_BASIC); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] expAddr [4] = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h00000000, 32'h00000004};
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0); m_address = (c == 0) ? 32'hFFFFFFF8 : 32'h0;
      #1;
      compared++; if (vector_valid !== (c == 6)) begin mismatched++; $display("[TB] FAIL wrap_valid c%0d got %b", c, vector_valid); end
      if (c >= 1 && c <= 4) begin
        compared++; if (mem_raddr !== expAddr[c-1]) begin mismatched++; $display("[TB] FAIL wrap_raddr c%0d got %h expected %h", c, mem_raddr, expAddr[c-1]); end
      end
      if (c == 6) begin
        compared++; if (output_vector !== VEC_WRAP) begin mismatched++; $display("[TB] FAIL wrap_vec got %h expected %h", output_vector, VEC_WRAP); end
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] expAddr [4] = '{32'h10, 32'h14, 32'h18, 32'h1C};
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0 || c == 2);
      m_address = (c == 0) ? 32'h10 : ((c == 2) ? 32'h80 : 32'h0);
      #1;
      compared++; if (stall_cpu !== (c <= 5)) begin mismatched++; $display("[TB] FAIL busy_stall c%0d got %b", c, stall_cpu); end
      compared++; if (mem_ren !== (c >= 1 && c <= 4)) begin mismatched++; $display("[TB] FAIL busy_ren c%0d got %b", c, mem_ren); end
      if (c >= 1 && c <= 4) begin
        compared++; if (mem_raddr !== expAddr[c-1]) begin mismatched++; $display("[TB] FAIL busy_raddr c%0d got %h expected %h", c, mem_raddr, expAddr[c-1]); end
      end
      if (c == 6) begin
        compared++; if (output_vector !== VEC_BASIC) begin mismatched++; $display("[TB] FAIL busy_vec got %h expected %h", output_vector, VEC_BASIC); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expAddr [8] = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0 || c == 6);
      m_address = (c == 0) ? 32'h10 : ((c == 6) ? 32'h20 : 32'h0);
      #1;
      compared++; if (stall_cpu !== (c <= 11)) begin mismatched++; $display("[TB] FAIL b2b_stall c%0d got %b", c, stall_cpu); end
      compared++; if (mem_ren !== ((c >= 1 && c <= 4) || (c >= 7 && c <= 10))) begin mismatched++; $display("[TB] FAIL b2b_ren c%0d got %b", c, mem_ren); end
      compared++; if (vector_valid !== (c == 6 || c == 12)) begin mismatched++; $display("[TB] FAIL b2b_valid c%0d got %b", c, vector_valid); end
      if (c >= 1 && c <= 4) begin
        compared++; if (mem_raddr !== expAddr[c-1]) begin mismatched++; $display("[TB] FAIL b2b_raddr c%0d got %h expected %h", c, mem_raddr, expAddr[c-1]); end
      end
      if (c >= 7 && c <= 10) begin
        compared++; if (mem_raddr !== expAddr[c-3]) begin mismatched++; $display("[TB] FAIL b2b_raddr c%0d got %h expected %h", c, mem_raddr, expAddr[c-3]); end
      end
      if (c >= 6 && c <= 11) begin
        compared++; if (output_vector !== VEC_BASIC) begin mismatched++; $display("[TB] FAIL b2b_vec1 c%0d got %h expected %h", c, output_vector, VEC_BASIC); end
      end
      if (c == 12) begin
        compared++; if (output_vector !== VEC_SECOND) begin mismatched++; $display("[TB] FAIL b2b_vec2 got %h expected %h", output_vector, VEC_SECOND); end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0); m_address = (c == 0) ? 32'h10 : 32'h0;
      rst = (c == 3);
      #1;
      if (c == 3) begin
        compared++; if (stall_cpu !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_stall_now got %b expected 0", stall_cpu); end
      end
      if (c >= 4) begin
        compared++; if (mem_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_ren c%0d got %b expected 0", c, mem_ren); end
        compared++; if (stall_cpu !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_stall c%0d got %b expected 0", c, stall_cpu); end
        compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_valid c%0d got %b expected 0", c, vector_valid); end
        compared++; if (output_vector !== 128'h0) begin mismatched++; $display("[TB] FAIL midrst_vec c%0d got %h expected 0", c, output_vector); end
      end
    end
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      mem_ren_v = (c == 0); m_address = (c == 0) ? 32'h20 : 32'h0;
      #1;
      compared++; if (vector_valid !== (c == 6)) begin mismatched++; $display("[TB] FAIL midrst_fresh_valid c%0d got %b", c, vector_valid); end
      if (c == 6) begin
        compared++; if (output_vector !== VEC_SECOND) begin mismatched++; $display("[TB] FAIL midrst_fresh_vec got %h expected %h", output_vector, VEC_SECOND); end
      end
    end
  endtask

  task automatic test_hold();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      mem_ren_v = 1'b0; m_address = 32'hDEADBEEF;
      #1;
      compared++; if (output_vector !== VEC_SECOND) begin mismatched++; $display("[TB] FAIL hold_vec c%0d got %h expected %h", c, output_vector, VEC_SECOND); end
      compared++; if (vector_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_valid c%0d got %b expected 0", c, vector_valid); end
      compared++; if (mem_ren !== 1'b0) begin mismatched++; $display("[TB] FAIL hold_ren c%0d got %b expected 0", c, mem_ren); end
    end
  endtask

  initial begin
    rst = 1'b1; mem_ren_v = 1'b0; m_address = 32'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
